// File: rtl/data_mem_responder.sv
// Data-memory responder for the RISC-V load/store port: valid/ready request,
// programmable wait states, byte/half/word lanes and sign/zero load extension.
module data_mem_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int          IDX_W    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int          AW       = IDX_W + 2;
    localparam logic [31:0] DEPTH_L  = 32'(DEPTH_WORDS);
    localparam logic [3:0]  CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;
    localparam bit          NO_WAIT  = (WAIT_CYCLES == 0);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t        r_state;
    logic [3:0]    r_cnt;
    logic          r_ready;
    logic          r_rsp_valid;
    logic [31:0]   r_rsp_rdata;
    logic          r_rsp_err;

    logic          r_we;
    logic [1:0]    r_size;
    logic          r_uns;
    logic [AW-1:0] r_addr;
    logic [31:0]   r_wdata;

    logic [31:0]   r_mem [DEPTH_WORDS];

    logic             w_accept;
    logic             w_err_in;
    logic             w_do_access;
    logic             w_a_we;
    logic [1:0]       w_a_size;
    logic             w_a_uns;
    logic [AW-1:0]    w_a_addr;
    logic [31:0]      w_a_wdata;
    logic [IDX_W-1:0] w_idx;
    logic [3:0]       w_be;
    logic [31:0]      w_wrep;
    logic [31:0]      w_rd_word;
    logic [31:0]      w_shifted;
    logic [31:0]      w_load_data;

    assign req_ready = r_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_err   = r_rsp_err;

    // With zero wait states the access happens on the acceptance edge itself,
    // so the access fields come straight from the request ports in IDLE.
    always_comb begin
        w_accept = reset_n & req_valid & r_ready;

        w_err_in = 1'b0;
        if (req_size == 2'b11)
            w_err_in = 1'b1;
        if ((req_size == 2'b01) && req_addr[0])
            w_err_in = 1'b1;
        if ((req_size == 2'b10) && (req_addr[1:0] != 2'b00))
            w_err_in = 1'b1;
        if ({2'b00, req_addr[31:2]} >= DEPTH_L)
            w_err_in = 1'b1;

        if (r_state == S_IDLE) begin
            w_a_we    = req_we;
            w_a_size  = req_size;
            w_a_uns   = req_unsigned;
            w_a_addr  = req_addr[AW-1:0];
            w_a_wdata = req_wdata;
        end else begin
            w_a_we    = r_we;
            w_a_size  = r_size;
            w_a_uns   = r_uns;
            w_a_addr  = r_addr;
            w_a_wdata = r_wdata;
        end

        w_do_access = 1'b0;
        if ((r_state == S_IDLE) && w_accept && !w_err_in && NO_WAIT)
            w_do_access = 1'b1;
        if ((r_state == S_WAIT) && (r_cnt == '0))
            w_do_access = 1'b1;

        w_idx = w_a_addr[AW-1:2];

        case (w_a_size)
            2'b00: begin
                w_be   = 4'b0001 << w_a_addr[1:0];
                w_wrep = {4{w_a_wdata[7:0]}};
            end
            2'b01: begin
                w_be   = w_a_addr[1] ? 4'b1100 : 4'b0011;
                w_wrep = {2{w_a_wdata[15:0]}};
            end
            default: begin
                w_be   = 4'b1111;
                w_wrep = w_a_wdata;
            end
        endcase

        w_rd_word = r_mem[w_idx];
        w_shifted = w_rd_word >> {w_a_addr[1:0], 3'b000};

        w_load_data = '0;
        if (!w_a_we) begin
            case (w_a_size)
                2'b00:
                    w_load_data = w_a_uns ? {24'b0, w_shifted[7:0]}
                                          : {{24{w_shifted[7]}}, w_shifted[7:0]};
                2'b01:
                    w_load_data = w_a_uns ? {16'b0, w_shifted[15:0]}
                                          : {{16{w_shifted[15]}}, w_shifted[15:0]};
                default:
                    w_load_data = w_rd_word;
            endcase
        end
    end

    // Backing array is not reset; stores only commit on the edge entering RESP.
    always_ff @(posedge clk) begin
        if (w_do_access && w_a_we) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (w_be[i])
                    r_mem[w_idx][8*i +: 8] <= w_wrep[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_ready     <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
            r_we        <= 1'b0;
            r_size      <= '0;
            r_uns       <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_we    <= req_we;
                        r_size  <= req_size;
                        r_uns   <= req_unsigned;
                        r_addr  <= req_addr[AW-1:0];
                        r_wdata <= req_wdata;
                        r_ready <= 1'b0;
                        if (w_err_in) begin
                            r_state     <= S_RESP;
                            r_rsp_valid <= 1'b1;
                            r_rsp_err   <= 1'b1;
                            r_rsp_rdata <= '0;
                        end else if (NO_WAIT) begin
                            r_state     <= S_RESP;
                            r_rsp_valid <= 1'b1;
                            r_rsp_err   <= 1'b0;
                            r_rsp_rdata <= w_load_data;
                        end else begin
                            r_state <= S_WAIT;
                            r_cnt   <= CNT_INIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (r_cnt == '0) begin
                        r_state     <= S_RESP;
                        r_rsp_valid <= 1'b1;
                        r_rsp_err   <= 1'b0;
                        r_rsp_rdata <= w_load_data;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                S_RESP: begin
                    r_state     <= S_IDLE;
                    r_ready     <= 1'b1;
                    r_rsp_valid <= 1'b0;
                    r_rsp_err   <= 1'b0;
                    r_rsp_rdata <= '0;
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_ready     <= 1'b1;
                    r_rsp_valid <= 1'b0;
                    r_rsp_err   <= 1'b0;
                    r_rsp_rdata <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder: byte-array reference model,
// directed scenarios, back-to-back throughput, reset-in-WAIT and random traffic.
module tb_data_mem_responder;

    localparam int DEPTH = 256;
    localparam int WAITC = 2;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    always #5 clk = ~clk;

    data_mem_responder #(
        .DEPTH_WORDS(DEPTH),
        .WAIT_CYCLES(WAITC)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_rdata    (rsp_rdata),
        .rsp_err      (rsp_err)
    );

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          due;
    } exp_t;

    exp_t       q[$];
    exp_t       me;
    logic [7:0] mm [0:4*DEPTH-1];
    int         n_cmp = 0;
    int         n_bad = 0;
    int         cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Memory as little-endian bytes; result latency counted in edges from acceptance.
    task automatic model(input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata, output exp_t e);
        int n;
        logic [31:0] v;
        e.err = (size == 2'd3) || (size == 2'd1 && addr % 2 != 0) ||
                (size == 2'd2 && addr % 4 != 0) || (addr >= 32'(4 * DEPTH));
        e.rdata = '0;
        e.due = e.err ? 1 : WAITC + 1;
        if (!e.err) begin
            n = 1 << size;
            if (we) begin
                for (int b = 0; b < n; b++) mm[addr + 32'(b)] = wdata[8*b +: 8];
            end else begin
                v = '0;
                for (int b = 0; b < n; b++) v[8*b +: 8] = mm[addr + 32'(b)];
                if (!uns && n < 4 && v[8*n-1])
                    for (int k = 8 * n; k < 32; k++) v[k] = 1'b1;
                e.rdata = v;
            end
        end
    endtask

    task automatic push_exp(input logic we, input logic [1:0] size, input logic uns,
                            input logic [31:0] addr, input logic [31:0] wdata);
        exp_t e;
        model(we, size, uns, addr, wdata, e);
        e.due = cyc + e.due;
        q.push_back(e);
    endtask

    task automatic issue(input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata, input bit track);
        bit got;
        got = 0;
        @(negedge clk);
        req_we = we; req_size = size; req_unsigned = uns; req_addr = addr; req_wdata = wdata;
        req_valid = 1'b1;
        for (int t = 0; t < 40; t++) begin
            if (req_ready === 1'b1) begin
                got = 1;
                break;
            end
            @(negedge clk);
        end
        chk("accept_wait", 32'(got), 32'd1);
        if (got && track) push_exp(we, size, uns, addr, wdata);
        @(negedge clk);
        req_valid = 1'b0;
        req_we = 1'($urandom); req_size = 2'($urandom); req_unsigned = 1'($urandom);
        req_addr = $urandom; req_wdata = $urandom;
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (rsp_valid === 1'b1) begin
                if (q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_rsp: got rsp_valid=1 expected none (cycle %0d)", cyc);
                end else begin
                    me = q.pop_front();
                    chk("rsp_cycle", 32'(cyc), 32'(me.due));
                    chk("rsp_err", 32'(rsp_err), 32'(me.err));
                    chk("rsp_rdata", rsp_rdata, me.rdata);
                end
            end else begin
                chk("idle_rdata", rsp_rdata, 32'd0);
                if (q.size() > 0 && cyc > q[0].due) begin
                    me = q.pop_front();
                    n_cmp++;
                    n_bad++;
                    $display("FAIL rsp_timeout: got no rsp_valid expected one by cycle %0d", me.due);
                end
            end
        end
    end

    initial begin
        int   last;
        int   lows;
        bit   got;
        int   r;
        logic [1:0]  sz;
        logic [31:0] a;

        req_valid = 1'b0; req_we = 1'b0; req_size = '0; req_unsigned = 1'b0;
        req_addr = '0; req_wdata = '0;
        #1 reset_n = 1'b0;
        req_valid = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_ready", 32'(req_ready), 32'd1);
        chk("reset_valid", 32'(rsp_valid), 32'd0);
        chk("reset_rdata", rsp_rdata, 32'd0);
        chk("reset_err", 32'(rsp_err), 32'd0);
        req_valid = 1'b0;
        reset_n = 1'b1;
        @(negedge clk);

        for (int w = 0; w < 16; w++) issue(1'b1, 2'd2, 1'b0, 32'(w * 4), $urandom, 1);

        issue(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, 1);
        issue(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 1);

        issue(1'b1, 2'd2, 1'b0, 32'h20, 32'h0, 1);
        issue(1'b1, 2'd0, 1'b0, 32'h21, 32'hA5A5A580, 1);
        issue(1'b0, 2'd0, 1'b0, 32'h21, 32'h0, 1);
        issue(1'b0, 2'd0, 1'b1, 32'h21, 32'h0, 1);
        issue(1'b0, 2'd2, 1'b0, 32'h20, 32'h0, 1);

        issue(1'b1, 2'd2, 1'b0, 32'h30, 32'h0, 1);
        issue(1'b1, 2'd1, 1'b0, 32'h32, 32'h5A5A8234, 1);
        issue(1'b0, 2'd2, 1'b0, 32'h30, 32'h0, 1);
        issue(1'b0, 2'd1, 1'b0, 32'h32, 32'h0, 1);
        issue(1'b0, 2'd1, 1'b1, 32'h32, 32'h0, 1);

        issue(1'b0, 2'd2, 1'b0, 32'h13, 32'h0, 1);
        issue(1'b1, 2'd1, 1'b0, 32'h11, 32'hFFFF, 1);
        issue(1'b0, 2'd3, 1'b0, 32'h10, 32'h0, 1);
        issue(1'b1, 2'd2, 1'b0, 32'h400, 32'h1, 1);
        issue(1'b1, 2'd0, 1'b0, 32'hFFFFFFFF, 32'h77, 1);
        issue(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 1);

        // Store cut off by reset while waiting: must leave no trace.
        issue(1'b1, 2'd2, 1'b0, 32'h10, 32'h12345678, 0);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            chk("ready_after_reset", 32'(req_ready), 32'd1);
        end
        issue(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 1);

        @(negedge clk);
        req_we = 1'b0; req_size = 2'd2; req_unsigned = 1'b0; req_addr = 32'h0;
        req_valid = 1'b1;
        last = 0;
        for (int k = 0; k < 5; k++) begin
            lows = 0;
            got = 0;
            for (int t = 0; t < 40; t++) begin
                if (req_ready === 1'b1) begin
                    got = 1;
                    break;
                end
                lows++;
                @(negedge clk);
            end
            chk("b2b_accept", 32'(got), 32'd1);
            push_exp(1'b0, 2'd2, 1'b0, req_addr, 32'h0);
            if (k > 0) begin
                chk("b2b_spacing", 32'(cyc - last), 32'd4);
                chk("b2b_ready_low", 32'(lows), 32'd3);
            end
            last = cyc;
            @(negedge clk);
            req_addr = 32'((k + 1) * 4);
        end
        req_valid = 1'b0;

        for (int n = 0; n < 200; n++) begin
            r = $urandom_range(0, 9);
            if (r < 8) begin
                sz = 2'($urandom_range(0, 2));
                a = 32'($urandom_range(0, 63));
                a = a & ~((32'd1 << sz) - 32'd1);
            end else if (r == 8) begin
                sz = 2'($urandom_range(0, 3));
                a = 32'($urandom_range(0, 63));
            end else begin
                sz = 2'($urandom_range(0, 3));
                a = $urandom;
                if (a < 32'(4 * DEPTH)) a = a + 32'(4 * DEPTH);
            end
            issue(1'($urandom), sz, 1'($urandom), a, $urandom, 1);
        end

        repeat (10) @(negedge clk);
        chk("queue_drained", 32'(q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
